nios2_oci_dct_packer: RTL and testbench
=======================================

Name: nios2_oci_dct_packer

Overview:
- Producer side of the direct-compressed-trace (DCT) frame interface.
- Packs a stream of 2-bit trace codes from the OCI trace logic into 30-bit frames (dct_buffer) with an entry count (dct_count).
- Presents each frame to the downstream frame consumer (trace test bench / trace store) through a 1-deep valid/ready output register.
- Sequences end-of-test: final flush, then test_ending / test_has_ended.

Parameters:
- CODE_W, 2, bits per trace code.
- SLOTS, 15, codes per full frame.
- BUF_W, 30, frame width; always CODE_W*SLOTS.
- CNT_W, 4, count width; SLOTS must fit.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- code_valid  in  1  trace code offered.
- code  in  CODE_W  trace code.
- code_ready  out  1  code accepted on clk when code_valid && code_ready.
- flush  in  1  single-cycle pulse: emit partial frame.
- end_req  in  1  single-cycle pulse: begin end-of-test sequence.
- dct_buffer  out  BUF_W  frame payload; oldest code in the highest occupied slot; unused upper bits zero.
- dct_count  out  CNT_W  valid codes in dct_buffer, 1..15.
- frame_valid  out  1  output register holds a frame.
- frame_ready  in  1  consumer takes the frame on clk when frame_valid && frame_ready.
- test_ending  out  1  end sequence in progress.
- test_has_ended  out  1  sticky; final frame consumed.

Behaviour:
- Reset (async, reset_n=0): acc=0, acc_cnt=0, flush_pend=0, state=RUN. Outputs: dct_buffer=0, dct_count=0, frame_valid=0, test_ending=0, test_has_ended=0.
- slot_free = !frame_valid || frame_ready.
- code_ready = (state==RUN) && slot_free. This is combinational from state, frame_valid and frame_ready only; it does not depend on code_valid.
- Accept: acc_n = {acc[BUF_W-CODE_W-1:0], code}; cnt_n = acc_cnt + 1.
- Full frame: if cnt_n == SLOTS, load output register with (acc_n, 15) and set frame_valid=1. Clear acc and acc_cnt in the same cycle.
- Otherwise: acc <= acc_n, acc_cnt <= cnt_n.
- Flush:
  - flush sets flush_pend.
  - Service when flush_pend (or flush this cycle) && slot_free: emit (acc incl. any code accepted this cycle, count) and clear acc and flush_pend.
  - Count 0 with no accept: no frame; flush_pend clears.
  - Flush coinciding with the 15th code: the single full frame satisfies it.
- Output register: frame_valid clears on handshake unless reloaded the same cycle. Back-to-back frames are allowed; throughput is one frame per cycle. Latency from the 15th accepted code to frame_valid is 1 cycle.
- Stability: dct_buffer and dct_count are stable while frame_valid && !frame_ready.
- FSM:
  - RUN: end_req -> ENDING, set flush_pend.
  - ENDING: test_ending=1, code_ready=0. Flush the residual. When acc_cnt==0 && !flush_pend && !frame_valid -> ENDED.
  - ENDED: test_ending=0, test_has_ended=1 sticky. Terminal until reset; flush and end_req are ignored.
- end_req in ENDING or ENDED is ignored. end_req coinciding with an accepted code: the code is included in the final flush.
- Reset mid-frame: partial acc is discarded, no frame is emitted, and all outputs return to reset values asynchronously.
- dct_count is never 0 while frame_valid=1.

Decomposition:
- Package nios2_oci_dct_pkg: CODE_W, SLOTS, BUF_W, CNT_W; state enum {RUN, ENDING, ENDED}; trace code constants (e.g. TAKEN=2'b10, NOT_TAKEN=2'b01, SYNC=2'b11).
- One sub-module, nios2_oci_dct_frame_reg: the 1-deep valid/ready output register. The packer and FSM stay in the top module.

Test Plan:
- Reset then 15 codes 2'b01 with frame_ready=1 -> one cycle after the 15th accept: frame_valid=1, dct_count=15, dct_buffer=30'h15555555; acc empties.
- Codes 11,10,01 then flush pulse -> dct_count=3, dct_buffer=30'h39. A second flush with empty acc -> no frame.
- Fill a frame with frame_ready=0, then offer more codes -> code_ready=0 and the frame holds stable. Raise frame_ready -> handshake, code_ready reasserts the same cycle, and the next code is accepted.
- 5 codes then end_req -> test_ending=1, code_ready=0, frame (count=5) emitted; after the consumer takes it, test_has_ended=1 and test_ending=0. Later code_valid or flush -> ignored.
- 14 codes, then flush in the same cycle as the 15th code -> exactly one frame, count=15; no extra empty or partial frame.
- Assert reset_n=0 after 7 codes mid-frame -> outputs zero immediately; after release, 15 codes produce count=15 with no stale bits.

Source files
------------

// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants and types for the DCT frame packer.
//   CODE_W : bits per trace code
//   SLOTS  : codes per full frame
//   BUF_W  : frame payload width (CODE_W*SLOTS)
//   CNT_W  : width of the per-frame code count
package nios2_oci_dct_pkg;
  localparam int CODE_W = 2;
  localparam int SLOTS  = 15;
  localparam int BUF_W  = CODE_W * SLOTS;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {RUN, ENDING, ENDED} dct_state_e;

  localparam logic [CODE_W-1:0] NOT_TAKEN = 2'b01;
  localparam logic [CODE_W-1:0] TAKEN     = 2'b10;
  localparam logic [CODE_W-1:0] SYNC      = 2'b11;
endpackage

// File: rtl/nios2_oci_dct_packer_if.sv
// Trace-code input handshake, frame output handshake and end-of-test
// status for the DCT packer.
//   master : code producer / frame consumer side
//   slave  : packer side
interface nios2_oci_dct_packer_if;
  import nios2_oci_dct_pkg::*;

  logic              code_valid;
  logic [CODE_W-1:0] code;
  logic              code_ready;
  logic              flush;
  logic              end_req;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              frame_valid;
  logic              frame_ready;
  logic              test_ending;
  logic              test_has_ended;

  modport master (
    output code_valid, code, flush, end_req, frame_ready,
    input  code_ready, dct_buffer, dct_count, frame_valid,
           test_ending, test_has_ended
  );

  modport slave (
    input  code_valid, code, flush, end_req, frame_ready,
    output code_ready, dct_buffer, dct_count, frame_valid,
           test_ending, test_has_ended
  );
endinterface

// File: rtl/nios2_oci_dct_frame_reg.sv
// One-deep valid/ready output register for packed frames.
//   clk, reset_n            : clock, async active-low reset
//   load, load_buffer/count : capture a new frame (only when slot is free)
//   frame_ready             : consumer accepts the held frame
//   frame_valid, dct_buffer, dct_count : held frame
module nios2_oci_dct_frame_reg
  import nios2_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [BUF_W-1:0] load_buffer,
  input  logic [CNT_W-1:0] load_count,
  input  logic             frame_ready,
  output logic             frame_valid,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count
);

  // Payload only changes on load, so it stays stable while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid <= 1'b0;
      dct_buffer  <= '0;
      dct_count   <= '0;
    end else if (load) begin
      frame_valid <= 1'b1;
      dct_buffer  <= load_buffer;
      dct_count   <= load_count;
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace codes into 30-bit DCT frames and sequences the
// end-of-test flush.
//   clk, reset_n : clock, async active-low reset
//   bus          : code handshake, flush/end_req pulses, frame handshake,
//                  test_ending / test_has_ended status
//
//   state  | meaning
//   RUN    | accepting codes, flushing on request
//   ENDING | no new codes; draining residual frame
//   ENDED  | final frame consumed; terminal until reset
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
(
  input logic                    clk,
  input logic                    reset_n,
  nios2_oci_dct_packer_if.slave  bus
);

  dct_state_e       state;
  logic [BUF_W-1:0] acc;
  logic [CNT_W-1:0] acc_cnt;
  logic             flush_pend;

  logic             slot_free;
  logic             code_ready;
  logic             accept;
  logic             flush_req;
  logic [BUF_W-1:0] cur_buf;
  logic [CNT_W-1:0] cur_cnt;
  logic [BUF_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             pend_d;
  logic             load;
  logic [BUF_W-1:0] load_buffer;
  logic [CNT_W-1:0] load_count;

  assign slot_free      = !bus.frame_valid || bus.frame_ready;
  assign code_ready     = (state == RUN) && slot_free;
  assign bus.code_ready = code_ready;
  assign accept         = bus.code_valid && code_ready;
  // Flush pulses are dead once the test has ended.
  assign flush_req      = flush_pend || (bus.flush && state != ENDED);

  always_comb begin
    // Accumulator view including a code accepted this cycle.
    cur_buf     = accept ? {acc[BUF_W-CODE_W-1:0], bus.code} : acc;
    cur_cnt     = accept ? acc_cnt + CNT_W'(1) : acc_cnt;
    acc_d       = cur_buf;
    cnt_d       = cur_cnt;
    pend_d      = flush_req;
    load        = 1'b0;
    load_buffer = cur_buf;
    load_count  = cur_cnt;
    if (accept && cur_cnt == CNT_W'(SLOTS)) begin
      // A full frame also satisfies any flush pending this cycle.
      load   = 1'b1;
      acc_d  = '0;
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (flush_req && slot_free) begin
      load   = (cur_cnt != '0);
      acc_d  = '0;
      cnt_d  = '0;
      pend_d = 1'b0;
    end
    if (bus.end_req && state == RUN) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= RUN;
      acc                <= '0;
      acc_cnt            <= '0;
      flush_pend         <= 1'b0;
      bus.test_ending    <= 1'b0;
      bus.test_has_ended <= 1'b0;
    end else begin
      acc        <= acc_d;
      acc_cnt    <= cnt_d;
      flush_pend <= pend_d;
      case (state)
        RUN: begin
          if (bus.end_req) begin
            state           <= ENDING;
            bus.test_ending <= 1'b1;
          end
        end
        ENDING: begin
          if (acc_cnt == '0 && !flush_pend && !bus.frame_valid) begin
            state              <= ENDED;
            bus.test_ending    <= 1'b0;
            bus.test_has_ended <= 1'b1;
          end
        end
        default: begin
          state <= ENDED;
        end
      endcase
    end
  end

  nios2_oci_dct_frame_reg u_frame_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_buffer (load_buffer),
    .load_count  (load_count),
    .frame_ready (bus.frame_ready),
    .frame_valid (bus.frame_valid),
    .dct_buffer  (bus.dct_buffer),
    .dct_count   (bus.dct_count)
  );

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
module tb_nios2_oci_dct_packer;
  import nios2_oci_dct_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nios2_oci_dct_packer_if bus();

  nios2_oci_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: list of pending codes, queue of expected frames.
  logic [1:0]  m_codes[$];
  logic [29:0] e_buf[$];
  int          e_cnt[$];
  int          m_mode = 0;   // 0 run, 1 ending, 2 ended
  bit          m_fp = 0;
  bit          prev_hold = 0;
  logic [29:0] prev_buf;
  logic [3:0]  prev_cnt;

  task automatic model_emit();
    logic [29:0] b;
    b = '0;
    foreach (m_codes[i]) b = {b[27:0], m_codes[i]};
    if (m_codes.size() > 0) begin
      e_buf.push_back(b);
      e_cnt.push_back(m_codes.size());
    end
    m_codes.delete();
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_valid", 32'(bus.frame_valid), 0);
      chk("rst_count", 32'(bus.dct_count), 0);
      chk("rst_buffer", 32'(bus.dct_buffer), 0);
      chk("rst_ending", 32'(bus.test_ending), 0);
      chk("rst_ended", 32'(bus.test_has_ended), 0);
      m_codes.delete(); e_buf.delete(); e_cnt.delete();
      m_mode = 0; m_fp = 0; prev_hold = 0;
    end else begin
      int  nm;
      bit  fp, sf, fv, fr;
      fv = bus.frame_valid; fr = bus.frame_ready;
      sf = !fv || fr;
      chk("test_ending", 32'(bus.test_ending), 32'(m_mode == 1));
      chk("test_has_ended", 32'(bus.test_has_ended), 32'(m_mode == 2));
      chk("code_ready", 32'(bus.code_ready), 32'(m_mode == 0 && sf));
      if (fv) chk("count_nonzero", 32'(bus.dct_count != 0), 1);
      if (prev_hold) begin
        chk("hold_valid", 32'(fv), 1);
        chk("hold_buffer", 32'(bus.dct_buffer), 32'(prev_buf));
        chk("hold_count", 32'(bus.dct_count), 32'(prev_cnt));
      end
      prev_hold = fv && !fr;
      prev_buf = bus.dct_buffer;
      prev_cnt = bus.dct_count;
      if (fv && fr) begin
        hs_cnt++;
        if (e_buf.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_frame: got count %0d buffer 0x%0h expected no frame", bus.dct_count, bus.dct_buffer);
        end else begin
          chk("frame_buffer", 32'(bus.dct_buffer), 32'(e_buf.pop_front()));
          chk("frame_count", 32'(bus.dct_count), 32'(e_cnt.pop_front()));
        end
      end
      // Predict the effect of the upcoming rising edge.
      nm = m_mode;
      if (m_mode == 1 && m_codes.size() == 0 && !m_fp && !fv) nm = 2;
      fp = m_fp || (bus.flush && m_mode != 2);
      if (bus.code_valid && bus.code_ready) m_codes.push_back(bus.code);
      if (m_codes.size() == SLOTS) begin
        model_emit(); fp = 0;
      end else if (fp && sf) begin
        model_emit(); fp = 0;
      end
      if (bus.end_req && m_mode == 0) begin
        fp = 1; nm = 1;
      end
      m_fp = fp;
      m_mode = nm;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_code(input logic [1:0] c, input bit with_flush);
    bit got;
    got = 0;
    bus.code_valid = 1'b1; bus.code = c; bus.flush = with_flush;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.code_ready) got = 1;
      else @(posedge clk);
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got code_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    bus.code_valid = 1'b0; bus.flush = 1'b0;
  endtask

  initial begin
    int hs0;
    bit seen;
    bus.code_valid = 0; bus.code = '0; bus.flush = 0; bus.end_req = 0; bus.frame_ready = 1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 1: fifteen NOT_TAKEN codes -> full frame one cycle after 15th accept
    for (int i = 0; i < 15; i++) send_code(NOT_TAKEN, 0);
    chk("t1_valid", 32'(bus.frame_valid), 1);
    chk("t1_count", 32'(bus.dct_count), 15);
    chk("t1_buffer", 32'(bus.dct_buffer), 32'h15555555);
    tick();

    // 2: partial frame via flush, then flush on empty produces nothing
    send_code(SYNC, 0); send_code(TAKEN, 0); send_code(NOT_TAKEN, 0);
    hs0 = hs_cnt;
    bus.flush = 1; tick(); bus.flush = 0;
    chk("t2_valid", 32'(bus.frame_valid), 1);
    chk("t2_count", 32'(bus.dct_count), 3);
    chk("t2_buffer", 32'(bus.dct_buffer), 32'h39);
    tick();
    bus.flush = 1; tick(); bus.flush = 0;
    tick();
    chk("t2_empty_flush", 32'(bus.frame_valid), 0);
    chk("t2_frames", 32'(hs_cnt - hs0), 1);

    // 3: back-pressure holds the frame and blocks codes
    bus.frame_ready = 0;
    for (int i = 0; i < 15; i++) send_code((i % 2 == 0) ? SYNC : TAKEN, 0);
    chk("t3_buffer", 32'(bus.dct_buffer), 32'h3BBBBBBB);
    bus.code_valid = 1; bus.code = NOT_TAKEN;
    repeat (3) begin
      @(negedge clk);
      chk("t3_blocked", 32'(bus.code_ready), 0);
      @(posedge clk); #1;
    end
    bus.frame_ready = 1;
    @(negedge clk);
    chk("t3_reassert", 32'(bus.code_ready), 1);
    @(posedge clk); #1;
    bus.code_valid = 0;
    chk("t3_drained", 32'(bus.frame_valid), 0);
    bus.flush = 1; tick(); bus.flush = 0;
    chk("t3_one_code", 32'(bus.dct_count), 1);
    chk("t3_one_buf", 32'(bus.dct_buffer), 32'(NOT_TAKEN));
    tick();

    // 4: end-of-test sequence
    send_code(TAKEN, 0); send_code(NOT_TAKEN, 0); send_code(SYNC, 0);
    send_code(TAKEN, 0); send_code(NOT_TAKEN, 0);
    bus.end_req = 1; tick(); bus.end_req = 0;
    chk("t4_ending", 32'(bus.test_ending), 1);
    chk("t4_no_ready", 32'(bus.code_ready), 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) if (bus.frame_valid) seen = 1; else tick();
    chk("t4_frame_seen", 32'(seen), 1);
    chk("t4_count", 32'(bus.dct_count), 5);
    chk("t4_buffer", 32'(bus.dct_buffer), 32'h279);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) if (bus.test_has_ended) seen = 1; else tick();
    chk("t4_ended", 32'(seen), 1);
    chk("t4_ending_low", 32'(bus.test_ending), 0);
    hs0 = hs_cnt;
    bus.code_valid = 1; bus.code = SYNC; bus.flush = 1; tick(); bus.flush = 0;
    bus.end_req = 1; tick(); bus.end_req = 0;
    repeat (3) tick();
    bus.code_valid = 0;
    chk("t4_ignored", 32'(hs_cnt - hs0), 0);
    chk("t4_sticky", 32'(bus.test_has_ended), 1);

    // 5: flush coinciding with the 15th code -> exactly one frame
    reset_n = 0; tick(); reset_n = 1; tick();
    hs0 = hs_cnt;
    for (int i = 0; i < 14; i++) send_code(SYNC, 0);
    send_code(TAKEN, 1);
    chk("t5_count", 32'(bus.dct_count), 15);
    chk("t5_buffer", 32'(bus.dct_buffer), 32'h3FFFFFFE);
    repeat (4) tick();
    chk("t5_frames", 32'(hs_cnt - hs0), 1);
    chk("t5_idle", 32'(bus.frame_valid), 0);

    // 6: reset mid-frame discards partial accumulator
    for (int i = 0; i < 7; i++) send_code(SYNC, 0);
    reset_n = 0; #1;
    chk("t6_rst_valid", 32'(bus.frame_valid), 0);
    chk("t6_rst_count", 32'(bus.dct_count), 0);
    chk("t6_rst_buffer", 32'(bus.dct_buffer), 0);
    tick(); reset_n = 1; tick();
    for (int i = 0; i < 15; i++) send_code(TAKEN, 0);
    chk("t6_count", 32'(bus.dct_count), 15);
    chk("t6_buffer", 32'(bus.dct_buffer), 32'h2AAAAAAA);
    repeat (3) tick();
    chk("final_no_pending", 32'(e_buf.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
